// File: rtl/vga_layer_compositor_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_layer_compositor_pkg: shared constants and types.  Revision 1.0
// ----------------------------------------------------------------------------
package vga_layer_compositor_pkg;

  // Terminal counts for a 100 MHz clock
  localparam int unsigned BLINK_3HZ = 16666666;
  localparam int unsigned BLINK_2HZ = 24999999;

  // Syncs are negative polarity, so the inactive level is high
  localparam logic SYNC_INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    SRC_BLANK = 2'd0,
    SRC_BG    = 2'd1,
    SRC_LAYER = 2'd2
  } pix_src_e;

endpackage
`default_nettype wire

// File: rtl/vga_layer_compositor_blink_divider.sv
`default_nettype none
// ----------------------------------------------------------------------------
// blink_divider: free-running counter that toggles its output on terminal count. Revision 1.0
// ----------------------------------------------------------------------------
module blink_divider #(
  parameter int CNT_W = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] max,
  output logic             blink
);

  logic [CNT_W-1:0] count;

  // >= so that a terminal count lowered mid-period wraps on the next clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      blink <= 1'b0;
    end else if (clr) begin
      count <= '0;
      blink <= 1'b0;
    end else if (count >= max) begin
      count <= '0;
      blink <= ~blink;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_layer_compositor: fixed-priority layer merge with blink gating and sync delay. Revision 1.0
// ----------------------------------------------------------------------------
module vga_layer_compositor
  import vga_layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS  = 6,
  parameter int IDX_W       = 3,
  parameter int RGB_W       = 8,
  parameter int BLINK_SEL_W = 1,
  parameter int CNT_W       = 25
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              pixel_tick,
  input  logic                              video_on,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic [NUM_LAYERS-1:0]             layer_on,
  input  logic [NUM_LAYERS-1:0]             layer_cond,
  input  logic [NUM_LAYERS-1:0]             layer_blink_en,
  input  logic [NUM_LAYERS*BLINK_SEL_W-1:0] layer_blink_sel,
  input  logic [NUM_LAYERS*RGB_W-1:0]       layer_rgb,
  input  logic [RGB_W-1:0]                  bg_rgb,
  input  logic [(2**BLINK_SEL_W)*CNT_W-1:0] blink_max,
  input  logic                              blink_clr,
  output logic [(2**BLINK_SEL_W)-1:0]       blink_out,
  output logic [RGB_W-1:0]                  rgb,
  output logic                              hsync,
  output logic                              vsync,
  output logic [IDX_W-1:0]                  layer_idx
);

  localparam int BLINK_CH = 2**BLINK_SEL_W;
  localparam logic [IDX_W-1:0] IDX_NONE = '1;

  genvar c;
  generate
    for (c = 0; c < BLINK_CH; c++) begin : g_blink
      blink_divider #(.CNT_W(CNT_W)) u_div (
        .clock (clock),
        .reset (reset),
        .clr   (blink_clr),
        .max   (blink_max[c*CNT_W +: CNT_W]),
        .blink (blink_out[c])
      );
    end
  endgenerate

  logic [NUM_LAYERS-1:0]  eligible;
  logic [BLINK_SEL_W-1:0] sel;

  always_comb begin
    eligible = '0;
    sel      = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      sel         = layer_blink_sel[i*BLINK_SEL_W +: BLINK_SEL_W];
      eligible[i] = layer_on[i] & layer_cond[i] & (~layer_blink_en[i] | blink_out[sel]);
    end
  end

  logic [IDX_W-1:0] win_idx;
  logic             win_hit;
  logic [RGB_W-1:0] win_rgb;

  // Scan from the bottom up so the lowest eligible index is the last write
  always_comb begin
    win_idx = IDX_NONE;
    win_hit = 1'b0;
    win_rgb = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_idx = IDX_W'(i);
        win_hit = 1'b1;
        win_rgb = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  pix_src_e         s1_src;
  logic [IDX_W-1:0] s1_idx;
  logic [RGB_W-1:0] s1_rgb;
  logic             s1_hsync;
  logic             s1_vsync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_src   <= SRC_BLANK;
      s1_idx   <= IDX_NONE;
      s1_rgb   <= '0;
      s1_hsync <= SYNC_INACTIVE;
      s1_vsync <= SYNC_INACTIVE;
    end else if (pixel_tick) begin
      if (!video_on) begin
        s1_src <= SRC_BLANK;
        s1_idx <= IDX_NONE;
      end else if (win_hit) begin
        s1_src <= SRC_LAYER;
        s1_idx <= win_idx;
      end else begin
        s1_src <= SRC_BG;
        s1_idx <= IDX_NONE;
      end
      s1_rgb   <= win_rgb;
      s1_hsync <= hsync_in;
      s1_vsync <= vsync_in;
    end
  end

  // Background is taken here so a colour change shows one tick sooner
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb       <= '0;
      layer_idx <= IDX_NONE;
      hsync     <= SYNC_INACTIVE;
      vsync     <= SYNC_INACTIVE;
    end else if (pixel_tick) begin
      case (s1_src)
        SRC_LAYER: rgb <= s1_rgb;
        SRC_BG:    rgb <= bg_rgb;
        default:   rgb <= '0;
      endcase
      layer_idx <= s1_idx;
      hsync     <= s1_hsync;
      vsync     <= s1_vsync;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_layer_compositor: scoreboard bench for the layer compositor. Revision 1.0
// ----------------------------------------------------------------------------
module tb_vga_layer_compositor;

  localparam int NL = 6;
  localparam int IW = 3;
  localparam int RW = 8;
  localparam int SW = 1;
  localparam int CW = 25;
  localparam int BC = 2;

  localparam int K_BLANK = 0;
  localparam int K_BG    = 1;
  localparam int K_HIT   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              pixel_tick = 1'b0;
  logic              video_on = 1'b1;
  logic              hsync_in = 1'b1;
  logic              vsync_in = 1'b1;
  logic [NL-1:0]     layer_on = '0;
  logic [NL-1:0]     layer_cond = '1;
  logic [NL-1:0]     layer_blink_en = '0;
  logic [NL*SW-1:0]  layer_blink_sel = '0;
  logic [NL*RW-1:0]  layer_rgb = 48'h60_50_40_30_20_10;
  logic [RW-1:0]     bg_rgb = 8'h1C;
  logic [BC*CW-1:0]  blink_max = {25'd100, 25'd3};
  logic              blink_clr = 1'b0;
  logic [BC-1:0]     blink_out;
  logic [RW-1:0]     rgb;
  logic              hsync;
  logic              vsync;
  logic [IW-1:0]     layer_idx;

  vga_layer_compositor #(
    .NUM_LAYERS(NL), .IDX_W(IW), .RGB_W(RW), .BLINK_SEL_W(SW), .CNT_W(CW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .pixel_tick      (pixel_tick),
    .video_on        (video_on),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .layer_on        (layer_on),
    .layer_cond      (layer_cond),
    .layer_blink_en  (layer_blink_en),
    .layer_blink_sel (layer_blink_sel),
    .layer_rgb       (layer_rgb),
    .bg_rgb          (bg_rgb),
    .blink_max       (blink_max),
    .blink_clr       (blink_clr),
    .blink_out       (blink_out),
    .rgb             (rgb),
    .hsync           (hsync),
    .vsync           (vsync),
    .layer_idx       (layer_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [7:0] rgb;
    logic [2:0] idx;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Clocks since the last clear of channel 0 (terminal count 3 -> period of 4)
  int unsigned blink_n = 0;
  always @(posedge clock or posedge reset) begin
    if (reset || blink_clr) blink_n <= 0;
    else                    blink_n <= blink_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_blank();
    exp_t e;
    e.kind = K_BLANK; e.rgb = 8'h00; e.idx = 3'h7; e.hs = 1'b1; e.vs = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_exp();
    exp_t e;
    logic b0;
    b0 = ((blink_n / 4) % 2) == 1;
    e.kind = K_BG; e.rgb = 8'h00; e.idx = 3'h7; e.hs = hsync_in; e.vs = vsync_in;
    if (!video_on) begin
      e.kind = K_BLANK;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (e.kind == K_BG && layer_on[i] && layer_cond[i] && (!layer_blink_en[i] || b0)) begin
          e.kind = K_HIT;
          e.idx  = 3'(i);
          e.rgb  = layer_rgb[i*RW +: RW];
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // One pixel: tick on the next edge, compare, then three idle clocks
  task automatic tick(input string tag);
    exp_t e;
    push_exp();
    pixel_tick = 1'b1;
    @(posedge clock); #1;
    pixel_tick = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == K_BG) e.rgb = bg_rgb;
      check({tag, "_rgb"}, 32'(rgb), 32'(e.rgb));
      check({tag, "_idx"}, 32'(layer_idx), 32'(e.idx));
      check({tag, "_hs"}, 32'(hsync), 32'(e.hs));
      check({tag, "_vs"}, 32'(vsync), 32'(e.vs));
      repeat (3) @(posedge clock);
      #1;
      check({tag, "_hold"}, 32'(rgb), 32'(e.rgb));
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_rgb", 32'(rgb), 32'h00);
    check("rst_idx", 32'(layer_idx), 32'h7);
    check("rst_hs", 32'(hsync), 32'h1);
    check("rst_vs", 32'(vsync), 32'h1);
    check("rst_blink", 32'(blink_out), 32'h0);
    reset = 1'b0;
    push_blank();

    tick("bg0");
    tick("bg1");

    layer_on = 6'b100110;
    repeat (3) tick("pri1");
    layer_on = 6'b100100;
    repeat (3) tick("pri2");

    layer_on = 6'b000000;
    tick("bgchg0");
    bg_rgb = 8'hA5;
    tick("bgchg1");
    tick("bgchg2");

    video_on = 1'b0;
    layer_on = 6'b000001;
    hsync_in = 1'b0;
    tick("hs_pulse");
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    tick("vs_pulse");
    vsync_in = 1'b1;
    tick("sync2");
    video_on = 1'b1;
    tick("sync3");
    tick("sync4");

    blink_clr = 1'b1;
    @(posedge clock); #1;
    blink_clr = 1'b0;
    check("blink0_clr", 32'(blink_out[0]), 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      check("blink0_period", 32'(blink_out[0]), 32'((k / 4) % 2));
    end

    layer_on       = 6'b001001;
    layer_blink_en = 6'b000001;
    repeat (8) tick("blink_pri");
    layer_blink_en = 6'b000000;
    layer_on       = 6'b000000;

    blink_clr = 1'b1;
    @(posedge clock); #1;
    blink_clr = 1'b0;
    repeat (50) @(posedge clock);
    #1;
    check("ch1_mid", 32'(blink_out[1]), 32'h0);
    blink_max[CW +: CW] = 25'd5;
    @(posedge clock); #1;
    check("ch1_lower_wrap", 32'(blink_out[1]), 32'h1);
    repeat (6) @(posedge clock);
    #1;
    check("ch1_period6", 32'(blink_out[1]), 32'h0);
    repeat (5) @(posedge clock);
    #1;
    blink_clr = 1'b1;
    @(posedge clock); #1;
    blink_clr = 1'b0;
    check("ch1_clr_wins", 32'(blink_out[1]), 32'h0);

    blink_max[CW +: CW] = 25'd0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      check("ch1_max0", 32'(blink_out[1]), 32'(k % 2));
    end
    blink_max[CW +: CW] = 25'd100;

    layer_rgb[7:0] = 8'hFF;
    layer_on       = 6'b000001;
    hsync_in       = 1'b0;
    tick("pre_rst0");
    tick("pre_rst1");
    tick("pre_rst2");
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rgb", 32'(rgb), 32'h00);
    check("async_rst_hs", 32'(hsync), 32'h1);
    check("async_rst_idx", 32'(layer_idx), 32'h7);
    hsync_in = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    push_blank();
    repeat (3) tick("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
